// File: rtl/onehot_scan_decoder.sv
// Registered one-hot strobe generator: direct decode of a loaded select value,
// or an auto-scan across all outputs with programmable dwell and direction.
//
// state | meaning
// IDLE  | direct decode active, or scan stopped (out blank in scan mode)
// RUN   | scan sequencing; busy high
module onehot_scan_decoder #(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  load,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   out,
  output logic [SEL_W-1:0]      idx,
  output logic                  busy,
  output logic                  wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;
  localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

  logic               state, state_n;
  logic [SEL_W-1:0]   idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DWELL_W-1:0] dwell_r, dwell_n;
  logic               blank, blank_n;
  logic               wrap_n;
  logic               show;
  logic               hold_out;
  logic [OUT_W-1:0]   out_n;

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    dwell_n  = dwell_r;
    blank_n  = blank;
    wrap_n   = 1'b0;
    show     = 1'b0;
    hold_out = 1'b0;
    if (!mode) begin
      state_n = IDLE;
      // Leaving a scan freezes the last strobe; direct rules resume next cycle.
      if (state == RUN) begin
        hold_out = 1'b1;
      end else if (!en) begin
        blank_n = 1'b1;
      end else if (load) begin
        idx_n   = sel;
        show    = 1'b1;
        blank_n = 1'b0;
      end else if (blank) begin
        show    = 1'b1;
        blank_n = 1'b0;
      end else begin
        hold_out = 1'b1;
      end
    end else if (stop) begin
      state_n = IDLE;
    end else if (start && en) begin
      state_n = RUN;
      idx_n   = sel;
      cnt_n   = dwell;
      dwell_n = dwell;
      show    = 1'b1;
    end else if (state == RUN && en) begin
      show = 1'b1;
      if (cnt != '0) begin
        cnt_n = cnt - 1'b1;
      end else begin
        idx_n  = dir ? idx - 1'b1 : idx + 1'b1;
        cnt_n  = dwell_r;
        wrap_n = dir ? (idx == '0) : (&idx);
      end
    end
    out_n = hold_out ? out : (show ? (ONE << idx_n) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      dwell_r <= '0;
      blank   <= 1'b0;
      wrap    <= 1'b0;
      out     <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      dwell_r <= dwell_n;
      blank   <= blank_n;
      wrap    <= wrap_n;
      out     <= out_n;
    end
  end

  assign busy = (state == RUN);

endmodule
